bram_vector_ctrl: RTL and testbench

Sequences the 32-bit dual-port vector BRAM (8192 words) for the ASIC tester. It shares the BRAM between two requesters: the host loader, which writes single 32-bit words, and the test sequencer, which fetches 128-bit test vectors. A vector fetch uses both ports over two read cycles and assembles the result into one 128-bit register. The block drives all BRAM port signals and is the only master of the BRAM.

---
 rtl/tester_pkg.sv | 24 ++
 rtl/bram_rr_arbiter.sv | 33 +++
 rtl/bram_vector_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bram_vector_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tester_pkg.sv
// Shared definitions for the vector BRAM controller.
//   state_e   : fetch sequencer states
//   VEC_WORDS : BRAM words per test vector
//   VEC_WIDTH : assembled vector width
//   word_ofs  : word offset inside a vector for a given read phase / port
package tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        CAP  = 2'd3
    } state_e;

    localparam int VEC_WORDS = 4;
    localparam int VEC_WIDTH = 128;

    // Vector word order: phase 0 reads words 0/1, phase 1 reads words 2/3,
    // port A always takes the even word. Word k lands in VEC_DATA[32k+31:32k].
    function automatic logic [1:0] word_ofs(input logic phase, input logic port_b);
        return {phase, port_b};
    endfunction

endpackage

// File: rtl/bram_rr_arbiter.sv
// Two-requester round-robin arbiter (fetch vs. host write).
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : arbitration allowed this cycle (controller idle)
//   req_fetch_i   : fetch request pending
//   req_wr_i      : host write request pending
//   adv_i         : a grant was taken this cycle; flips the priority flag
//   gnt_fetch_o   : fetch granted
//   gnt_wr_o      : host write granted
module bram_rr_arbiter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_fetch_i,
    input  logic req_wr_i,
    input  logic adv_i,
    output logic gnt_fetch_o,
    output logic gnt_wr_o
);

    // 0: fetch wins a tie, 1: write wins a tie
    logic prio_wr_q, prio_wr_d;

    assign prio_wr_d = adv_i ? ~prio_wr_q : prio_wr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prio_wr_q <= 1'b0;
        else         prio_wr_q <= prio_wr_d;
    end

    assign gnt_fetch_o = en_i & req_fetch_i & (~req_wr_i | ~prio_wr_q);
    assign gnt_wr_o    = en_i & req_wr_i & (~req_fetch_i | prio_wr_q);

endmodule

// File: rtl/bram_vector_ctrl.sv
// Vector BRAM controller: shares a dual-port 32-bit BRAM between single-word
// host writes and 128-bit vector fetches (two 2-port read cycles).
//   CLK, RST_N                     : clock, async active-low reset
//   HOST_WR_VALID/READY/ADDR/DATA  : host word write (READY combinational)
//   VEC_COUNT                      : number of loaded vectors
//   FETCH_REQ/READY/IDX            : vector fetch request
//   VEC_VALID, VEC_ERR, VEC_DATA   : fetch result (pulse), range error, vector
//   EN/WE/ADDR/DIN/DOUT _A/_B      : BRAM ports (port B read-only)
// Optional macro BRAM_CTRL_AUTOINC_EN: index comes from an internal wrapping
// pointer instead of FETCH_IDX; adds input FETCH_PTR_CLR.
module bram_vector_ctrl
    import tester_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 13,
    parameter int VEC_IDX_BITS  = RAM_ADDR_BITS - 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     HOST_WR_VALID,
    output logic                     HOST_WR_READY,
    input  logic [RAM_ADDR_BITS-1:0] HOST_WR_ADDR,
    input  logic [RAM_WIDTH-1:0]     HOST_WR_DATA,
    input  logic [VEC_IDX_BITS:0]    VEC_COUNT,
    input  logic                     FETCH_REQ,
    input  logic [VEC_IDX_BITS-1:0]  FETCH_IDX,
`ifdef BRAM_CTRL_AUTOINC_EN
    input  logic                     FETCH_PTR_CLR,
`endif
    output logic                     FETCH_READY,
    output logic                     VEC_VALID,
    output logic                     VEC_ERR,
    output logic [VEC_WIDTH-1:0]     VEC_DATA,
    output logic                     EN_A,
    output logic                     WE_A,
    output logic [RAM_ADDR_BITS-1:0] ADDR_A,
    output logic [RAM_WIDTH-1:0]     DIN_A,
    input  logic [RAM_WIDTH-1:0]     DOUT_A,
    output logic                     EN_B,
    output logic                     WE_B,
    output logic [RAM_ADDR_BITS-1:0] ADDR_B,
    output logic [RAM_WIDTH-1:0]     DIN_B,
    input  logic [RAM_WIDTH-1:0]     DOUT_B
);

    localparam int HALF_W = VEC_WIDTH / VEC_WORDS * 2;

    state_e                    state_q, state_d;
    logic [VEC_IDX_BITS-1:0]   idx_q, idx_d;
    logic                      err_pend_q, err_pend_d;
    logic                      vec_valid_q, vec_err_q;
    logic [VEC_WIDTH-1:0]      vec_data_q;
    logic [HALF_W-1:0]         lo_q;

    logic                      idle, rd, phase;
    logic                      gnt_fetch, gnt_wr;
    logic [VEC_IDX_BITS-1:0]   fetch_idx;
    logic                      in_range;

    assign idle  = (state_q == IDLE);
    assign rd    = (state_q == RD0) || (state_q == RD1);
    assign phase = (state_q == RD1);

    bram_rr_arbiter u_arb (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .en_i        (idle),
        .req_fetch_i (FETCH_REQ),
        .req_wr_i    (HOST_WR_VALID),
        .adv_i       (gnt_fetch | gnt_wr),
        .gnt_fetch_o (gnt_fetch),
        .gnt_wr_o    (gnt_wr)
    );

`ifdef BRAM_CTRL_AUTOINC_EN
    logic [VEC_IDX_BITS-1:0] ptr_q, ptr_d;
    logic [VEC_IDX_BITS:0]   ptr_inc;
    logic                    unused_fetch_idx;

    assign unused_fetch_idx = ^FETCH_IDX;
    assign fetch_idx        = ptr_q;
    assign ptr_inc          = {1'b0, ptr_q} + (VEC_IDX_BITS+1)'(1);

    // Pointer advances on accept, so a clear during a fetch still lands
    // before the next accept. A stale pointer (VEC_COUNT shrank) restarts at 0.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_fetch)
            ptr_d = (!in_range || ptr_inc == VEC_COUNT) ? '0 : ptr_inc[VEC_IDX_BITS-1:0];
        if (FETCH_PTR_CLR)
            ptr_d = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    assign fetch_idx = FETCH_IDX;
`endif

    assign in_range = ({1'b0, fetch_idx} < VEC_COUNT);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_pend_d = 1'b0;
        case (state_q)
            IDLE: if (gnt_fetch) begin
                if (in_range) begin
                    idx_d   = fetch_idx;
                    state_d = RD0;
                end else begin
                    // out of range: no BRAM access, error pulse next cycle
                    err_pend_d = 1'b1;
                end
            end
            RD0:     state_d = RD1;
            RD1:     state_d = CAP;
            CAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            err_pend_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_err_q   <= 1'b0;
            vec_data_q  <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_pend_q  <= err_pend_d;
            vec_valid_q <= (state_q == CAP) | err_pend_q;
            vec_err_q   <= err_pend_q;
            // low half is staged so VEC_DATA only changes on completion
            if (state_q == RD1) lo_q       <= {DOUT_B, DOUT_A};
            if (state_q == CAP) vec_data_q <= {DOUT_B, DOUT_A, lo_q};
        end
    end

    assign FETCH_READY   = idle;
    assign HOST_WR_READY = gnt_wr;
    assign VEC_VALID     = vec_valid_q;
    assign VEC_ERR       = vec_err_q;
    assign VEC_DATA      = vec_data_q;

    assign EN_A   = gnt_wr | rd;
    assign WE_A   = gnt_wr;
    assign ADDR_A = gnt_wr ? HOST_WR_ADDR : {idx_q, word_ofs(phase, 1'b0)};
    assign DIN_A  = HOST_WR_DATA;

    assign EN_B   = rd;
    assign WE_B   = 1'b0;
    assign ADDR_B = {idx_q, word_ofs(phase, 1'b1)};
    assign DIN_B  = '0;

endmodule

// File: tb/tb_bram_vector_ctrl.sv
// Self-checking bench for bram_vector_ctrl: BRAM model, directed scenarios,
// then randomized traffic checked cycle by cycle against a transaction-level
// reference (busy window + scheduled result events + word-array memory).
module tb_bram_vector_ctrl;

    localparam int AW = 13;
    localparam int IW = 11;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          HOST_WR_VALID, HOST_WR_READY;
    logic [AW-1:0] HOST_WR_ADDR;
    logic [31:0]   HOST_WR_DATA;
    logic [IW:0]   VEC_COUNT;
    logic          FETCH_REQ, FETCH_READY;
    logic [IW-1:0] FETCH_IDX;
    logic          VEC_VALID, VEC_ERR;
    logic [127:0]  VEC_DATA;
    logic          EN_A, WE_A, EN_B, WE_B;
    logic [AW-1:0] ADDR_A, ADDR_B;
    logic [31:0]   DIN_A, DIN_B, DOUT_A, DOUT_B;
`ifdef BRAM_CTRL_AUTOINC_EN
    logic          FETCH_PTR_CLR = 1'b0;
`endif

    always #5 CLK = ~CLK;

    bram_vector_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .HOST_WR_VALID(HOST_WR_VALID), .HOST_WR_READY(HOST_WR_READY),
        .HOST_WR_ADDR(HOST_WR_ADDR), .HOST_WR_DATA(HOST_WR_DATA),
        .VEC_COUNT(VEC_COUNT), .FETCH_REQ(FETCH_REQ), .FETCH_IDX(FETCH_IDX),
`ifdef BRAM_CTRL_AUTOINC_EN
        .FETCH_PTR_CLR(FETCH_PTR_CLR),
`endif
        .FETCH_READY(FETCH_READY), .VEC_VALID(VEC_VALID), .VEC_ERR(VEC_ERR),
        .VEC_DATA(VEC_DATA),
        .EN_A(EN_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DIN_A(DIN_A), .DOUT_A(DOUT_A),
        .EN_B(EN_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .DIN_B(DIN_B), .DOUT_B(DOUT_B)
    );

    // BRAM: one-cycle read latency, read-before-write on port A
    logic [31:0] mem [8192];
    always @(posedge CLK) begin
        if (EN_A) begin
            if (WE_A) mem[ADDR_A] <= DIN_A;
            DOUT_A <= mem[ADDR_A];
        end
        if (EN_B) DOUT_B <= mem[ADDR_B];
    end

    // reference model state
    logic [31:0]  ref_mem [8192];
    int           busy;        // cycles the controller is still unavailable
    bit           wr_turn;     // write wins the next tie
    logic [127:0] m_vdata;
    bit           ev_vld [8];
    bit           ev_err [8];
    logic [127:0] ev_data [8];
    int           cyc_n;
    int           ptr;
    bit           obs_wr, obs_acc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        busy = 0; wr_turn = 0; m_vdata = '0; ptr = 0;
        for (int i = 0; i < 8; i++) begin ev_vld[i] = 0; ev_err[i] = 0; ev_data[i] = '0; end
    endtask

    // called at the falling edge: check this cycle, then apply the upcoming edge
    task automatic model_step(input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                              input logic fr, input logic [IW-1:0] fi);
        int s, t, idx;
        bit idle, g_w, g_f;
        s = cyc_n % 8;
        if (ev_vld[s] && !ev_err[s]) m_vdata = ev_data[s];
        chk("vec_valid", 128'(VEC_VALID), 128'(ev_vld[s]));
        chk("vec_err", 128'(VEC_ERR), 128'(ev_err[s]));
        chk("vec_data", VEC_DATA, m_vdata);
        ev_vld[s] = 0; ev_err[s] = 0;

        idle = (busy == 0);
        g_w  = idle && wv && (!fr || wr_turn);
        g_f  = idle && fr && (!wv || !wr_turn);
        chk("fetch_ready", 128'(FETCH_READY), 128'(idle));
        chk("wr_ready", 128'(HOST_WR_READY), 128'(g_w));
        chk("en_a", 128'(EN_A), 128'(g_w || busy >= 2));
        chk("we_a", 128'(WE_A), 128'(g_w));
        chk("en_b", 128'(EN_B), 128'(busy >= 2));
        chk("we_b", 128'(WE_B), 128'(1'b0));
        obs_wr  = HOST_WR_READY;
        obs_acc = FETCH_READY & fr & ~HOST_WR_READY;

        if (busy > 0) busy--;
        if (g_w) begin
            ref_mem[wa] = wd;
            wr_turn = !wr_turn;
        end
        if (g_f) begin
            wr_turn = !wr_turn;
`ifdef BRAM_CTRL_AUTOINC_EN
            idx = ptr;
`else
            idx = int'(fi);
`endif
            if (idx < int'(VEC_COUNT)) begin
                t = (s + 4) % 8;
                busy = 3;
                ev_vld[t] = 1; ev_err[t] = 0;
                ev_data[t] = {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
`ifdef BRAM_CTRL_AUTOINC_EN
                ptr = (idx + 1 == int'(VEC_COUNT)) ? 0 : idx + 1;
`endif
            end else begin
                t = (s + 2) % 8;
                ev_vld[t] = 1; ev_err[t] = 1;
`ifdef BRAM_CTRL_AUTOINC_EN
                ptr = 0;
`endif
            end
        end
`ifdef BRAM_CTRL_AUTOINC_EN
        if (FETCH_PTR_CLR) ptr = 0;
`endif
        cyc_n++;
    endtask

    // one clock cycle of stimulus; entered and left at posedge+1
    task automatic cyc(input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic fr, input logic [IW-1:0] fi);
        HOST_WR_VALID = wv; HOST_WR_ADDR = wa; HOST_WR_DATA = wd;
        FETCH_REQ = fr; FETCH_IDX = fi;
        @(negedge CLK);
        model_step(wv, wa, wd, fr, fi);
        @(posedge CLK); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    int wcnt, fcnt;

    initial begin
        for (int i = 0; i < 8192; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        model_clear();
        cyc_n = 0;
        RST_N = 1'b0;
        HOST_WR_VALID = 0; HOST_WR_ADDR = '0; HOST_WR_DATA = '0;
        FETCH_REQ = 0; FETCH_IDX = '0; VEC_COUNT = 12'd8;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_valid", 128'(VEC_VALID), 128'(1'b0));
        chk("reset_err", 128'(VEC_ERR), 128'(1'b0));
        chk("reset_data", VEC_DATA, 128'(0));
        chk("reset_ready", 128'(FETCH_READY), 128'(1'b1));
        RST_N = 1'b1;

        // load words 0..31, fetch vector 3
        for (int a = 0; a < 32; a++) cyc(1'b1, AW'(a), 32'hA000_0000 + 32'(a), 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, IW'(3));
        idle_cycles(4);
`ifndef BRAM_CTRL_AUTOINC_EN
        chk("fetch3_data", VEC_DATA, 128'hA000000F_A000000E_A000000D_A000000C);
`endif

        // out-of-range index
        cyc(1'b0, '0, '0, 1'b1, IW'(8));
        idle_cycles(3);
`ifndef BRAM_CTRL_AUTOINC_EN
        chk("oor_hold", VEC_DATA, 128'hA000000F_A000000E_A000000D_A000000C);
`endif

        // both requesters held high: grants must alternate
        wcnt = 0; fcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, AW'(200 + i), $urandom, 1'b1, IW'(1));
            wcnt += int'(obs_wr);
            fcnt += int'(obs_acc);
        end
        idle_cycles(4);
        chk("rr_balance", 128'((wcnt - fcnt <= 1) && (fcnt - wcnt <= 1)), 128'(1'b1));
        chk("rr_no_starve", 128'((wcnt >= 3) && (fcnt >= 3)), 128'(1'b1));

        // write word 4n+2 in the completion cycle, then refetch n
        cyc(1'b0, '0, '0, 1'b1, IW'(5));
        idle_cycles(3);
        cyc(1'b1, AW'(22), 32'h5555_1234, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, IW'(5));
        idle_cycles(4);
`ifndef BRAM_CTRL_AUTOINC_EN
        chk("rewrite_word2", 128'(VEC_DATA[95:64]), 128'(32'h5555_1234));
        chk("rewrite_word0", 128'(VEC_DATA[31:0]), 128'(32'hA000_0014));
`endif

        // reset while the fetch is in RD1
        cyc(1'b0, '0, '0, 1'b1, IW'(2));
        cyc(1'b0, '0, '0, 1'b0, '0);
        RST_N = 1'b0;
        #1;
        chk("abort_valid", 128'(VEC_VALID), 128'(1'b0));
        chk("abort_data", VEC_DATA, 128'(0));
        chk("abort_err", 128'(VEC_ERR), 128'(1'b0));
        model_clear();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        chk("abort_ready", 128'(FETCH_READY), 128'(1'b1));
        idle_cycles(6);

`ifdef BRAM_CTRL_AUTOINC_EN
        for (int a = 0; a < 12; a++) cyc(1'b1, AW'(a), 32'hB000_0000 + 32'(a), 1'b0, '0);
        VEC_COUNT = 12'd3;
        FETCH_PTR_CLR = 1'b1;
        idle_cycles(1);
        FETCH_PTR_CLR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, '0, '0, 1'b1, '0);
            idle_cycles(3);
            chk("ainc_idx", 128'(VEC_DATA[31:0]), 128'(32'hB000_0000 + 32'(4 * (k % 3))));
        end
        FETCH_PTR_CLR = 1'b1;
        idle_cycles(1);
        FETCH_PTR_CLR = 1'b0;
        cyc(1'b0, '0, '0, 1'b1, '0);
        idle_cycles(3);
        chk("ainc_clr", 128'(VEC_DATA[31:0]), 128'(32'hB000_0000));
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) VEC_COUNT = 12'($urandom_range(0, 16));
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
                1'($urandom_range(0, 9) < 4), IW'($urandom_range(0, 17)));
        end
        idle_cycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
